// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the RISC-V multicycle control path:
//   opcode constants, FSM state encoding, instruction classes,
//   ALU operation classes, and the Imm_sel / ALU_control / Result_src /
//   operand-mux encodings used by multicycle_ctrl and alu_decoder.
//   Helper functions classify an opcode and pick its immediate format.
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // FSM states
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_e;

    // Instruction classes derived from the opcode
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_R       = 4'd1,
        CLS_I       = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LUI     = 4'd6,
        CLS_AUIPC   = 4'd7,
        CLS_JAL     = 4'd8,
        CLS_JALR    = 4'd9
    } instr_class_e;

    // ALU operation class handed from the FSM to alu_decoder
    typedef enum logic [1:0] {
        ALUOP_ADD = 2'd0,
        ALUOP_SUB = 2'd1,
        ALUOP_R   = 2'd2,
        ALUOP_I   = 2'd3
    } alu_op_e;

    // ALU_control encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Imm_sel encodings
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Result_src encodings
    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    // Operand mux encodings
    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    function automatic instr_class_e classify(input logic [6:0] opcode);
        case (opcode)
            OP_REG:    return CLS_R;
            OP_IMM:    return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_LUI:    return CLS_LUI;
            OP_AUIPC:  return CLS_AUIPC;
            OP_JAL:    return CLS_JAL;
            OP_JALR:   return CLS_JALR;
            default:   return CLS_ILLEGAL;
        endcase
    endfunction

    // R-type has no immediate; it shares the I encoding as a harmless default.
    function automatic logic [2:0] imm_format(input instr_class_e cls);
        case (cls)
            CLS_STORE:          return IMM_S;
            CLS_BRANCH:         return IMM_B;
            CLS_LUI, CLS_AUIPC: return IMM_U;
            CLS_JAL:            return IMM_J;
            default:            return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
//   Combinational ALU control decode.
//   Ports:
//     alu_op      in  2  operation class from the FSM (ADD, SUB, R-type, I-type)
//     funct3      in  3  instr[14:12]
//     funct7_b5   in  1  instr[30]; selects SUB/SRA for R-type, SRAI for I-type
//     alu_control out 4  ALU operation code
// ---------------------------------------------------------------------------
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_R, ALUOP_I: begin
                case (funct3)
                    // instr[30] is part of the immediate for ADDI, so only
                    // R-type may turn funct3=000 into a subtract.
                    3'b000: alu_control = (alu_op == ALUOP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b011: alu_control = ALU_SLTU;
                    3'b100: alu_control = ALU_XOR;
                    // SRA and SRAI both carry instr[30]=1.
                    3'b101: alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control = ALU_OR;
                    3'b111: alu_control = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle RISC-V control FSM: FETCH, DECODE, EXECUTE, MEMORY,
//   WRITEBACK (+TRAP). Memory accesses use a ready handshake; stalled
//   cycles are counted and a sticky Mem_timeout flags a saturated counter.
//
//   Build option: define ILLEGAL_TRAP_EN to send unknown opcodes to a TRAP
//   state held until reset; otherwise an unknown opcode retires as a NOP
//   straight from DECODE.
//
//   Parameters:
//     WAIT_CNT_W  width of the wait-state counter (timeout at 2**W-1 stalls)
//   Ports:
//     clk, reset              clock, synchronous active-high reset
//     Opcode/Funct3/Funct7_b5 instruction fields from the IR
//     Zero                    ALU zero flag
//     Mem_ready               memory handshake
//     Mem_read/Mem_write      memory strobes
//     IR_write/PC_write       register enables; PC_src selects PC+4 / ALU
//     Reg_write, Result_src   register-file write enable and data select
//     ALU_src_A/B, ALU_control ALU operand muxes and operation
//     Imm_sel                 immediate format (valid DECODE..retirement)
//     Instr_done              one-cycle retirement pulse
//     Mem_timeout             sticky wait-counter saturation flag
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic [2:0] Funct3,
    input  logic       Funct7_b5,
    input  logic       Zero,
    input  logic       Mem_ready,
    output logic       Mem_read,
    output logic       Mem_write,
    output logic       IR_write,
    output logic       PC_write,
    output logic       PC_src,
    output logic       Reg_write,
    output logic [1:0] ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic [3:0] ALU_control,
    output logic [2:0] Imm_sel,
    output logic [1:0] Result_src,
    output logic       Instr_done,
    output logic       Mem_timeout
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = '1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE = WAIT_CNT_W'(1);

    state_e                state;
    state_e                state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_next;
    logic                  timeout_q;

    instr_class_e          cls;
    alu_op_e               alu_op;
    logic [3:0]            alu_control_dec;

    logic                  mem_cycle;
    logic                  stalled;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  ir_wr;
    logic                  pc_wr;
    logic                  pc_sel;
    logic                  reg_wr;
    logic [1:0]            src_a;
    logic [1:0]            src_b;
    logic [2:0]            imm_raw;
    logic [1:0]            res_src;
    logic                  done;

    assign cls = classify(Opcode);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (Funct3),
        .funct7_b5   (Funct7_b5),
        .alu_control (alu_control_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (wait_cnt_next == WAIT_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next state and raw (pre-reset-gating) control outputs.
    always_comb begin
        state_next = state;
        mem_cycle  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_sel     = 1'b0;
        reg_wr     = 1'b0;
        src_a      = SRCA_RS1;
        src_b      = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        res_src    = RES_ALU;
        done       = 1'b0;

        case (state)
            S_FETCH: begin
                mem_cycle = 1'b1;
                mem_rd    = 1'b1;
                src_a     = SRCA_PC;
                src_b     = SRCB_FOUR;
                if (Mem_ready) begin
                    ir_wr      = 1'b1;
                    pc_wr      = 1'b1;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                // Precompute the branch target (PC + imm) while the
                // register file is read; the datapath latches it.
                src_a = SRCA_PC;
                src_b = SRCB_IMM;
                if (cls == CLS_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
                    state_next = S_TRAP;
`else
                    done       = 1'b1;
                    state_next = S_FETCH;
`endif
                end else begin
                    state_next = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                case (cls)
                    CLS_R: begin
                        alu_op     = ALUOP_R;
                        state_next = S_WRITEBACK;
                    end
                    CLS_I: begin
                        src_b      = SRCB_IMM;
                        alu_op     = ALUOP_I;
                        state_next = S_WRITEBACK;
                    end
                    CLS_LUI: begin
                        src_a      = SRCA_ZERO;
                        src_b      = SRCB_IMM;
                        state_next = S_WRITEBACK;
                    end
                    CLS_AUIPC: begin
                        src_a      = SRCA_PC;
                        src_b      = SRCB_IMM;
                        state_next = S_WRITEBACK;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        src_b      = SRCB_IMM;
                        state_next = S_MEMORY;
                    end
                    CLS_BRANCH: begin
                        // ALU compares rs1/rs2; the target came from DECODE.
                        // Funct3[0] distinguishes BNE from BEQ.
                        alu_op     = ALUOP_SUB;
                        pc_sel     = 1'b1;
                        pc_wr      = Zero ^ Funct3[0];
                        done       = 1'b1;
                        state_next = S_FETCH;
                    end
                    CLS_JAL: begin
                        src_a      = SRCA_PC;
                        src_b      = SRCB_IMM;
                        pc_sel     = 1'b1;
                        pc_wr      = 1'b1;
                        state_next = S_WRITEBACK;
                    end
                    CLS_JALR: begin
                        src_b      = SRCB_IMM;
                        pc_sel     = 1'b1;
                        pc_wr      = 1'b1;
                        state_next = S_WRITEBACK;
                    end
                    default: begin
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_MEMORY: begin
                mem_cycle = 1'b1;
                src_b     = SRCB_IMM;
                if (cls == CLS_STORE) begin
                    mem_wr = 1'b1;
                    if (Mem_ready) begin
                        done       = 1'b1;
                        state_next = S_FETCH;
                    end
                end else begin
                    mem_rd = 1'b1;
                    if (Mem_ready) begin
                        state_next = S_WRITEBACK;
                    end
                end
            end

            S_WRITEBACK: begin
                reg_wr = 1'b1;
                done   = 1'b1;
                case (cls)
                    CLS_LOAD:          res_src = RES_MEM;
                    CLS_JAL, CLS_JALR: res_src = RES_PC4;
                    default:           res_src = RES_ALU;
                endcase
                state_next = S_FETCH;
            end

            S_TRAP: begin
                state_next = S_TRAP;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Immediate format is held from DECODE until the instruction retires.
    always_comb begin
        imm_raw = IMM_I;
        if (state == S_DECODE || state == S_EXECUTE ||
            state == S_MEMORY || state == S_WRITEBACK) begin
            imm_raw = imm_format(cls);
        end
    end

    // Wait counter: counts stalled memory cycles, saturates instead of
    // wrapping; any completed access or state change clears it.
    always_comb begin
        stalled = mem_cycle && !Mem_ready;
        if (!stalled) begin
            wait_cnt_next = '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt_next = wait_cnt + WAIT_ONE;
        end else begin
            wait_cnt_next = wait_cnt;
        end
    end

    // All outputs are forced low while reset is asserted so an aborted
    // instruction cannot leak a write or retirement pulse.
    assign Mem_read    = !reset && mem_rd;
    assign Mem_write   = !reset && mem_wr;
    assign IR_write    = !reset && ir_wr;
    assign PC_write    = !reset && pc_wr;
    assign PC_src      = !reset && pc_sel;
    assign Reg_write   = !reset && reg_wr;
    assign Instr_done  = !reset && done;
    assign Mem_timeout = !reset && timeout_q;
    assign ALU_src_A   = reset ? 2'd0 : src_a;
    assign ALU_src_B   = reset ? 2'd0 : src_b;
    assign ALU_control = reset ? 4'd0 : alu_control_dec;
    assign Imm_sel     = reset ? 3'd0 : imm_raw;
    assign Result_src  = reset ? 2'd0 : res_src;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Table-driven bench for multicycle_ctrl: each vector is one instruction
//   with hand-computed latency, strobe counts and decode values; hand-written
//   sequences cover reset, wait-state timeout, reset mid-load and the
//   illegal-opcode path (build option ILLEGAL_TRAP_EN).
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic       Funct7_b5;
    logic       Zero;
    logic       Mem_ready;
    logic       Mem_read;
    logic       Mem_write;
    logic       IR_write;
    logic       PC_write;
    logic       PC_src;
    logic       Reg_write;
    logic [1:0] ALU_src_A;
    logic [1:0] ALU_src_B;
    logic [3:0] ALU_control;
    logic [2:0] Imm_sel;
    logic [1:0] Result_src;
    logic       Instr_done;
    logic       Mem_timeout;

    multicycle_ctrl #(.WAIT_CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .Funct3      (Funct3),
        .Funct7_b5   (Funct7_b5),
        .Zero        (Zero),
        .Mem_ready   (Mem_ready),
        .Mem_read    (Mem_read),
        .Mem_write   (Mem_write),
        .IR_write    (IR_write),
        .PC_write    (PC_write),
        .PC_src      (PC_src),
        .Reg_write   (Reg_write),
        .ALU_src_A   (ALU_src_A),
        .ALU_src_B   (ALU_src_B),
        .ALU_control (ALU_control),
        .Imm_sel     (Imm_sel),
        .Result_src  (Result_src),
        .Instr_done  (Instr_done),
        .Mem_timeout (Mem_timeout)
    );

    always #5 clk = ~clk;

    // Expected ALU_control codes
    localparam int A_ADD = 0, A_SUB = 1, A_SLTU = 4, A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         fstall;
        int         mstall;
        int         cycles;
        int         n_rw;
        int         n_mw;
        int         n_mr;
        int         n_pcw;
        int         res;
        int         alu;
        int         imm;
    } vec_t;

    typedef struct {
        int         cycles;
        int         n_rw;
        int         n_mw;
        int         n_mr;
        int         n_pcw;
        int         n_done;
        int         res;
        int         alu;
        int         imm;
        int         both;
        int         expired;
    } obs_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int actual, input int expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Runs one instruction starting in FETCH (called just after a rising
    // edge). Mem_ready is driven low for the requested number of memory
    // cycles in the fetch and memory phases; elsewhere it is held high.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fstall, input int mstall,
                             output obs_t o);
        int   fcnt;
        int   mcnt;
        logic fetched;
        o = '{cycles: 0, n_rw: 0, n_mw: 0, n_mr: 0, n_pcw: 0, n_done: 0,
              res: 0, alu: 0, imm: 0, both: 0, expired: 0};
        Opcode = op; Funct3 = f3; Funct7_b5 = f7; Zero = z;
        fcnt = 0; mcnt = 0; fetched = 1'b0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            if (Mem_read || Mem_write) begin
                if (!fetched) begin Mem_ready = (fcnt >= fstall); fcnt++; end
                else          begin Mem_ready = (mcnt >= mstall); mcnt++; end
            end else begin
                Mem_ready = 1'b1;
            end
            #1;
            if (Reg_write) begin o.n_rw++; o.res = int'(Result_src); end
            if (Mem_write) o.n_mw++;
            if (Mem_read)  o.n_mr++;
            if (PC_write)  o.n_pcw++;
            if (Mem_read && Mem_write) o.both = 1;
            if (cyc == fstall + 2) o.imm = int'(Imm_sel);
            if (cyc == fstall + 3) o.alu = int'(ALU_control);
            if (IR_write) fetched = 1'b1;
            if (Instr_done) begin
                o.n_done++;
                o.cycles = cyc;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        o.expired = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int   cnt;

        //                name        op     f3    f7    z     fs ms cyc rw mw mr pcw res alu     imm
        vecs.push_back('{"ADD",       7'h33, 3'd0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_ADD,  0});
        vecs.push_back('{"SUB",       7'h33, 3'd0, 1'b1, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_SUB,  0});
        vecs.push_back('{"SRA",       7'h33, 3'd5, 1'b1, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_SRA,  0});
        vecs.push_back('{"SLTU",      7'h33, 3'd3, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_SLTU, 0});
        vecs.push_back('{"OR",        7'h33, 3'd6, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_OR,   0});
        vecs.push_back('{"ADDI_b30",  7'h13, 3'd0, 1'b1, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_ADD,  0});
        vecs.push_back('{"SRAI",      7'h13, 3'd5, 1'b1, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_SRA,  0});
        vecs.push_back('{"SRLI",      7'h13, 3'd5, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_SRL,  0});
        vecs.push_back('{"ANDI",      7'h13, 3'd7, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_AND,  0});
        vecs.push_back('{"LUI",       7'h37, 3'd0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_ADD,  3});
        vecs.push_back('{"AUIPC",     7'h17, 3'd0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0, A_ADD,  3});
        vecs.push_back('{"JAL",       7'h6F, 3'd0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 2, 2, A_ADD,  4});
        vecs.push_back('{"JALR",      7'h67, 3'd0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 2, 2, A_ADD,  0});
        vecs.push_back('{"LW",        7'h03, 3'd2, 1'b0, 1'b0, 0, 0, 5, 1, 0, 2, 1, 1, A_ADD,  0});
        vecs.push_back('{"LW_stall3", 7'h03, 3'd2, 1'b0, 1'b0, 0, 3, 8, 1, 0, 5, 1, 1, A_ADD,  0});
        vecs.push_back('{"SW",        7'h23, 3'd2, 1'b0, 1'b0, 0, 0, 4, 0, 1, 1, 1, 0, A_ADD,  1});
        vecs.push_back('{"SW_stall2", 7'h23, 3'd2, 1'b0, 1'b0, 0, 2, 6, 0, 3, 1, 1, 0, A_ADD,  1});
        vecs.push_back('{"BEQ_taken", 7'h63, 3'd0, 1'b0, 1'b1, 0, 0, 3, 0, 0, 1, 2, 0, A_SUB,  2});
        vecs.push_back('{"BEQ_not",   7'h63, 3'd0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 1, 1, 0, A_SUB,  2});
        vecs.push_back('{"BNE_taken", 7'h63, 3'd1, 1'b0, 1'b0, 0, 0, 3, 0, 0, 1, 2, 0, A_SUB,  2});
        vecs.push_back('{"BNE_not",   7'h63, 3'd1, 1'b0, 1'b1, 0, 0, 3, 0, 0, 1, 1, 0, A_SUB,  2});
        vecs.push_back('{"ADD_fstall",7'h33, 3'd0, 1'b0, 1'b0, 2, 0, 6, 1, 0, 3, 1, 0, A_ADD,  0});
`ifndef ILLEGAL_TRAP_EN
        vecs.push_back('{"NOP_7F",    7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, 2, 0, 0, 1, 1, 0, A_ADD,  0});
`endif

        // Reset cycle: every output low even with Mem_ready high.
        reset = 1'b1; Mem_ready = 1'b1; Opcode = 7'h33; Funct3 = 3'd0; Funct7_b5 = 1'b0; Zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_cycle_outputs",
              int'({Mem_read, Mem_write, IR_write, PC_write, PC_src, Reg_write, ALU_src_A, ALU_src_B,
                    ALU_control, Imm_sel, Result_src, Instr_done, Mem_timeout}), 0);

        // First cycle after reset: fetching, nothing else.
        reset = 1'b0; Mem_ready = 1'b0;
        #1;
        check("post_reset_mem_read", int'(Mem_read), 1);
        check("post_reset_strobes",
              int'({Mem_write, IR_write, PC_write, Reg_write, Instr_done, Mem_timeout}), 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z,
                      vecs[i].fstall, vecs[i].mstall, o);
            check({vecs[i].name, " expired"},    o.expired, 0);
            check({vecs[i].name, " cycles"},     o.cycles,  vecs[i].cycles);
            check({vecs[i].name, " reg_write"},  o.n_rw,    vecs[i].n_rw);
            check({vecs[i].name, " mem_write"},  o.n_mw,    vecs[i].n_mw);
            check({vecs[i].name, " mem_read"},   o.n_mr,    vecs[i].n_mr);
            check({vecs[i].name, " pc_write"},   o.n_pcw,   vecs[i].n_pcw);
            check({vecs[i].name, " result_src"}, o.res,     vecs[i].res);
            check({vecs[i].name, " alu_ctrl"},   o.alu,     vecs[i].alu);
            check({vecs[i].name, " imm_sel"},    o.imm,     vecs[i].imm);
            check({vecs[i].name, " rd_wr_both"}, o.both,    0);
            #1;
            check({vecs[i].name, " done_once"},  int'(Instr_done), 0);
            check({vecs[i].name, " refetch"},    int'(Mem_read), 1);
            Mem_ready = 1'b0;
        end

        // Fetch stalls until the counter saturates; the flag appears after
        // the 15th stalled cycle, stays set and the FSM keeps waiting.
        Opcode = 7'h03; Funct3 = 3'd2; Funct7_b5 = 1'b0; Zero = 1'b0; Mem_ready = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
        end
        check("timeout_before_sat", int'(Mem_timeout), 0);
        @(posedge clk); #1;
        check("timeout_at_sat", int'(Mem_timeout), 1);
        check("timeout_still_fetching", int'({Mem_read, IR_write}), 2);
        @(posedge clk); #1;
        check("timeout_hold", int'(Mem_timeout), 1);
        Mem_ready = 1'b1;
        #1;
        check("timeout_fetch_completes", int'(IR_write), 1);
        @(posedge clk); #1;
        check("timeout_sticky", int'(Mem_timeout), 1);
        @(posedge clk); #1;          // EXECUTE
        Mem_ready = 1'b0;
        @(posedge clk); #1;          // MEMORY, stalled
        check("lw_in_memory", int'(Mem_read), 1);
        @(posedge clk); #1;          // still MEMORY
        reset = 1'b1;
        #1;
        check("reset_mid_lw_outputs",
              int'({Mem_read, Mem_write, IR_write, PC_write, PC_src, Reg_write, ALU_src_A, ALU_src_B,
                    ALU_control, Imm_sel, Result_src, Instr_done, Mem_timeout}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("after_abort_fetch", int'(Mem_read), 1);
        check("after_abort_timeout_clear", int'(Mem_timeout), 0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (Reg_write || Mem_write || Instr_done || IR_write) cnt++;
            @(posedge clk); #1;
        end
        check("after_abort_no_writes", cnt, 0);
        run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 0, o);
        check("after_abort_lw_cycles", o.cycles, 5);
        check("after_abort_lw_result", o.res, 1);

`ifdef ILLEGAL_TRAP_EN
        // Unknown opcode: fetched, then stuck in TRAP with every strobe low.
        Opcode = 7'h7F; Funct3 = 3'd0; Mem_ready = 1'b1;
        #1;
        check("trap_fetch", int'(IR_write), 1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (Instr_done) cnt++;
        end
        check("trap_no_done", cnt, 0);
        check("trap_outputs",
              int'({Mem_read, Mem_write, IR_write, PC_write, Reg_write, Instr_done}), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("trap_exit_by_reset", int'(Mem_read), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
